// File: rtl/switch_data_conditioner.sv
// rtl/switch_data_conditioner.sv - synchronised, debounced switch word presented as a valid/ready transaction
//
// Ports:
//   clk        in   single rising-edge clock
//   reset      in   synchronous active-high reset
//   sw         in   [N_SW]        raw asynchronous switch levels
//   data_out   out  [DATA_WIDTH]  debounced switch word, zero-extended
//   data_valid out  data_out/chg_mask hold a transaction
//   data_ready in   consumer accepts the transaction when high with data_valid
//   chg_mask   out  [N_SW]        channels changed since the last accepted transaction
//   overrun    out  sticky: an intermediate debounced word was never presented

module switch_data_conditioner #(
   parameter int N_SW       = 4,
   parameter int DATA_WIDTH = 8,
   parameter int DEBOUNCE   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N_SW-1:0]       sw,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   input  logic                  data_ready,
   output logic [N_SW-1:0]       chg_mask,
   output logic                  overrun
);

   localparam int            CW       = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   typedef enum logic {
      S_IDLE    = 1'b0,
      S_PRESENT = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [N_SW-1:0] sync1_q, sync1_d;
   logic [N_SW-1:0] sync2_q, sync2_d;
   logic [N_SW-1:0] stable_q, stable_d;
   logic [N_SW-1:0] stable_prev_q, stable_prev_d;
   logic [N_SW-1:0] pending_q, pending_d;
   logic [N_SW-1:0] chg_mask_q, chg_mask_d;
   logic [N_SW-1:0] data_q, data_d;
   logic [CW-1:0]   cnt_q [N_SW];
   logic [CW-1:0]   cnt_d [N_SW];
   logic            overrun_q, overrun_d;
   logic [N_SW-1:0] chg;
   logic [N_SW-1:0] next_mask;

   // One-cycle pulse on each channel whose debounced level just moved.
   assign chg       = stable_q ^ stable_prev_q;
   assign next_mask = pending_q | chg;

   // Synchroniser and per-channel debounce: a new level is accepted only after
   // DEBOUNCE consecutive synchronised samples disagree with the stable level.
   always_comb begin
      sync1_d       = sw;
      sync2_d       = sync1_q;
      stable_prev_d = stable_q;
      stable_d      = stable_q;
      for (int ch = 0; ch < N_SW; ch++) begin
         cnt_d[ch] = cnt_q[ch];
         if (sync2_q[ch] == stable_q[ch]) begin
            cnt_d[ch] = '0;
         end else if (cnt_q[ch] == CNT_LAST) begin
            stable_d[ch] = sync2_q[ch];
            cnt_d[ch]    = '0;
         end else begin
            cnt_d[ch] = cnt_q[ch] + CW'(1);
         end
      end
   end

   // Presentation FSM. Changes arriving while a word is held are folded into
   // pending_q so the next accepted word reports every channel that moved.
   always_comb begin
      state_d    = state_q;
      data_d     = data_q;
      chg_mask_d = chg_mask_q;
      pending_d  = pending_q;
      overrun_d  = overrun_q;
      case (state_q)
         S_IDLE: begin
            if (chg != '0) begin
               data_d     = stable_q;
               chg_mask_d = chg;
               state_d    = S_PRESENT;
            end
         end
         S_PRESENT: begin
            if (data_ready) begin
               if (next_mask != '0) begin
                  data_d     = stable_q;
                  chg_mask_d = next_mask;
                  pending_d  = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               // A second change while one is already pending means the
               // intermediate word will never be seen by the consumer.
               if ((chg != '0) && (pending_q != '0)) begin
                  overrun_d = 1'b1;
               end
               pending_d = next_mask;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_IDLE;
         sync1_q       <= '0;
         sync2_q       <= '0;
         stable_q      <= '0;
         stable_prev_q <= '0;
         pending_q     <= '0;
         chg_mask_q    <= '0;
         data_q        <= '0;
         overrun_q     <= 1'b0;
         for (int ch = 0; ch < N_SW; ch++) begin
            cnt_q[ch] <= '0;
         end
      end else begin
         state_q       <= state_d;
         sync1_q       <= sync1_d;
         sync2_q       <= sync2_d;
         stable_q      <= stable_d;
         stable_prev_q <= stable_prev_d;
         pending_q     <= pending_d;
         chg_mask_q    <= chg_mask_d;
         data_q        <= data_d;
         overrun_q     <= overrun_d;
         for (int ch = 0; ch < N_SW; ch++) begin
            cnt_q[ch] <= cnt_d[ch];
         end
      end
   end

   assign data_out   = DATA_WIDTH'(data_q);
   assign data_valid = (state_q == S_PRESENT);
   assign chg_mask   = chg_mask_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_switch_data_conditioner.sv
// tb/tb_switch_data_conditioner.sv - self-checking bench for switch_data_conditioner

module tb_switch_data_conditioner;

   localparam int N_SW = 4;
   localparam int DW   = 8;
   localparam int DB   = 4;

   logic            clk;
   logic            reset;
   logic [N_SW-1:0] sw;
   logic [DW-1:0]   data_out;
   logic            data_valid;
   logic            data_ready;
   logic [N_SW-1:0] chg_mask;
   logic            overrun;

   int n_checks;
   int n_fail;

   switch_data_conditioner #(
      .N_SW       (N_SW),
      .DATA_WIDTH (DW),
      .DEBOUNCE   (DB)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .sw         (sw),
      .data_out   (data_out),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .chg_mask   (chg_mask),
      .overrun    (overrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a channel's debounced level flips once the last DB
   // synchronised samples all disagree with it; the consumer side keeps one
   // presented word plus a union of changes not yet reported.
   bit [N_SW-1:0] m_s1, m_s2, m_stable, m_prev, m_pend, m_mask;
   bit [N_SW-1:0] hist [DB];
   bit [DW-1:0]   m_dout;
   bit            m_valid, m_ovr;

   task automatic tick();
      bit [N_SW-1:0] chg, st_old, st_new;
      bit            all_diff;
      @(posedge clk);
      if (reset) begin
         m_s1 = '0; m_s2 = '0; m_stable = '0; m_prev = '0; m_pend = '0;
         m_mask = '0; m_dout = '0; m_valid = 0; m_ovr = 0;
         for (int i = 0; i < DB; i++) hist[i] = '0;
      end else begin
         st_old = m_stable;
         chg    = m_stable ^ m_prev;
         for (int i = DB - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = m_s2;
         st_new = st_old;
         for (int ch = 0; ch < N_SW; ch++) begin
            all_diff = 1;
            for (int i = 0; i < DB; i++)
               if (hist[i][ch] == st_old[ch]) all_diff = 0;
            if (all_diff) st_new[ch] = ~st_old[ch];
         end
         m_stable = st_new;
         m_prev   = st_old;
         m_s2     = m_s1;
         m_s1     = sw;
         if (!m_valid) begin
            if (chg != 0) begin
               m_dout = DW'(st_old); m_mask = chg; m_valid = 1;
            end
         end else if (data_ready) begin
            if ((m_pend | chg) != 0) begin
               m_dout = DW'(st_old); m_mask = m_pend | chg; m_pend = '0;
            end else begin
               m_valid = 0;
            end
         end else begin
            if (chg != 0 && m_pend != 0) m_ovr = 1;
            m_pend = m_pend | chg;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1; data_ready = 1;
      for (int i = 0; i < 3; i++) begin
         sw = N_SW'($urandom);
         tick();
      end
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", data_valid); end
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_out); end
      n_checks++;
      if (chg_mask !== 4'b0000) begin n_fail++; $display("FAIL reset_mask got %b want 0000", chg_mask); end
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b want 0", overrun); end
      sw = '0; reset = 0;
      repeat (4) tick();
   endtask

   task automatic test_glitch();
      bit seen;
      seen = 0;
      sw = 4'b0001;
      repeat (3) tick();
      sw = 4'b0000;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (data_valid) seen = 1;
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL glitch_valid got %b want 0", seen); end
      n_checks++;
      if (data_out !== 8'h00) begin n_fail++; $display("FAIL glitch_data got %h want 00", data_out); end
   endtask

   task automatic test_latency();
      int edges;
      data_ready = 1;
      sw = 4'b0101;
      edges = 0;
      while (!data_valid && edges < 20) begin
         tick();
         edges++;
      end
      n_checks++;
      if (edges !== 7) begin n_fail++; $display("FAIL latency_edges got %0d want 7", edges); end
      n_checks++;
      if (data_out !== 8'h05) begin n_fail++; $display("FAIL latency_data got %h want 05", data_out); end
      n_checks++;
      if (chg_mask !== 4'b0101) begin n_fail++; $display("FAIL latency_mask got %b want 0101", chg_mask); end
      tick();
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL latency_single got %b want 0", data_valid); end
   endtask

   task automatic test_backpressure();
      int edges;
      sw = '0; reset = 1; tick(); reset = 0;
      data_ready = 0;
      sw = 4'b0001;
      edges = 0;
      while (!data_valid && edges < 20) begin tick(); edges++; end
      n_checks++;
      if (data_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first_valid got %b want 1", data_valid); end
      sw = 4'b0011;
      repeat (10) tick();
      n_checks++;
      if (data_out !== 8'h01 || chg_mask !== 4'b0001 || data_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_hold got %h/%b v=%b want 01/0001 v=1", data_out, chg_mask, data_valid);
      end
      data_ready = 1;
      tick();
      n_checks++;
      if (data_out !== 8'h03 || chg_mask !== 4'b0010 || data_valid !== 1'b1) begin
         n_fail++; $display("FAIL bp_second got %h/%b v=%b want 03/0010 v=1", data_out, chg_mask, data_valid);
      end
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL bp_overrun got %b want 0", overrun); end
      tick();
      n_checks++;
      if (data_valid !== 1'b0) begin n_fail++; $display("FAIL bp_idle got %b want 0", data_valid); end
      data_ready = 0;
   endtask

   task automatic test_overrun();
      sw = '0; reset = 1; tick(); reset = 0;
      data_ready = 0;
      sw = 4'b0001; repeat (10) tick();
      n_checks++;
      if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_early got %b want 0", overrun); end
      sw = 4'b0011; repeat (10) tick();
      sw = 4'b0111; repeat (10) tick();
      n_checks++;
      if (overrun !== 1'b1 || data_out !== 8'h01) begin
         n_fail++; $display("FAIL ovr_set got ovr=%b data=%h want ovr=1 data=01", overrun, data_out);
      end
      data_ready = 1;
      tick();
      n_checks++;
      if (data_out !== 8'h07 || chg_mask !== 4'b0110) begin
         n_fail++; $display("FAIL ovr_second got %h/%b want 07/0110", data_out, chg_mask);
      end
      tick();
      n_checks++;
      if (data_valid !== 1'b0 || overrun !== 1'b1) begin
         n_fail++; $display("FAIL ovr_sticky got v=%b ovr=%b want v=0 ovr=1", data_valid, overrun);
      end
      data_ready = 0;
   endtask

   task automatic test_reset_mid();
      int edges;
      sw = 4'b0101;
      repeat (10) tick();
      n_checks++;
      if (data_valid !== 1'b1 || data_out !== 8'h05) begin
         n_fail++; $display("FAIL rmid_hold got v=%b data=%h want v=1 data=05", data_valid, data_out);
      end
      reset = 1; tick(); reset = 0;
      n_checks++;
      if (data_valid !== 1'b0 || data_out !== 8'h00 || overrun !== 1'b0 || chg_mask !== 4'b0000) begin
         n_fail++; $display("FAIL rmid_clear got v=%b data=%h ovr=%b mask=%b want 0/00/0/0000",
                            data_valid, data_out, overrun, chg_mask);
      end
      data_ready = 1;
      edges = 0;
      while (!data_valid && edges < 20) begin tick(); edges++; end
      n_checks++;
      if (edges !== 7 || data_out !== 8'h05 || chg_mask !== 4'b0101) begin
         n_fail++; $display("FAIL rmid_relaunch got edges=%0d %h/%b want 7 05/0101", edges, data_out, chg_mask);
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 1) == 0) sw = N_SW'($urandom);
            else sw = sw ^ N_SW'(1 << $urandom_range(0, N_SW - 1));
            hold = $urandom_range(1, 10);
         end
         hold--;
         data_ready = ($urandom_range(0, 3) != 0);
         reset = ($urandom_range(0, 599) == 0);
         tick();
         n_checks++;
         if (data_valid !== m_valid) begin
            n_fail++; $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, data_valid, m_valid);
         end
         n_checks++;
         if (data_out !== m_dout || chg_mask !== m_mask) begin
            n_fail++; $display("FAIL rnd_word cyc=%0d got %h/%b want %h/%b", cyc, data_out, chg_mask, m_dout, m_mask);
         end
         n_checks++;
         if (overrun !== m_ovr) begin
            n_fail++; $display("FAIL rnd_overrun cyc=%0d got %b want %b", cyc, overrun, m_ovr);
         end
      end
      reset = 0;
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      reset = 1; sw = '0; data_ready = 0;
      test_reset();
      test_glitch();
      test_latency();
      test_backpressure();
      test_overrun();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/switch_data_conditioner.md
SWITCH_DATA_CONDITIONER -- requirements
Module: switch_data_conditioner

Interface
REQ-001 SHALL provide parameter N_SW, default 4: number of switch channels, legal range 1 to 16.
REQ-002 SHALL provide parameter DATA_WIDTH, default 8: output word width, required >= N_SW.
REQ-003 SHALL provide parameter DEBOUNCE, default 4: consecutive synchronised cycles a new level must persist, legal range 1 to 255.
REQ-004 SHALL provide port: clk  input  1  single clock, all logic on rising edge.
REQ-005 SHALL provide port: reset  input  1  synchronous, active-high reset.
REQ-006 SHALL provide port: sw  input  N_SW  raw asynchronous switch levels.
REQ-007 SHALL provide port: data_out  output  DATA_WIDTH  debounced switch word, zero-extended.
REQ-008 SHALL provide port: data_valid  output  1  data_out/chg_mask hold a transaction.
REQ-009 SHALL provide port: data_ready  input  1  consumer accepts the transaction when high with data_valid.
REQ-010 SHALL provide port: chg_mask  output  N_SW  channels whose debounced level changed since the last accepted transaction.
REQ-011 SHALL provide port: overrun  output  1  sticky flag: an intermediate debounced word was never presented.

Function
REQ-012 SHALL pass each sw bit through a two-flop synchroniser (sync1, sync2) before any other use.
REQ-013 SHALL keep, per channel, a stable bit and a debounce counter of ceil(log2(DEBOUNCE+1)) bits.
REQ-014 SHALL, per channel each edge: if sync2 == stable, counter <= 0; else if counter == DEBOUNCE-1, stable <= sync2 and counter <= 0; else counter <= counter+1.
REQ-015 SHALL clear a channel's counter whenever sync2 returns to stable before the count completes (glitch rejected, no transaction).
REQ-016 SHALL register stable into stable_prev each edge and form chg = stable XOR stable_prev (combinational, one-cycle pulse per channel).
REQ-017 SHALL implement a two-state FSM: IDLE (data_valid=0) and PRESENT (data_valid=1).
REQ-018 SHALL, in IDLE with chg != 0, load data_out <= zero-extended stable, chg_mask <= chg, and enter PRESENT.
REQ-019 SHALL, in IDLE with chg == 0, hold all outputs.
REQ-020 SHALL, in PRESENT, hold data_out and chg_mask constant until data_valid && data_ready.
REQ-021 SHALL, in PRESENT, accumulate pending_mask <= pending_mask | chg each edge without handshake.
REQ-022 SHALL, on handshake with (pending_mask | chg) != 0, reload data_out <= stable, chg_mask <= pending_mask | chg, clear pending_mask, and remain PRESENT (back-to-back, no bubble).
REQ-023 SHALL, on handshake with (pending_mask | chg) == 0, return to IDLE with data_valid=0 the next cycle.
REQ-024 SHALL set overrun when chg != 0 in PRESENT without handshake while pending_mask != 0; overrun clears only on reset.
REQ-025 SHALL drive data_out bits [DATA_WIDTH-1:N_SW] to 0 at all times.
REQ-026 SHALL give latency: sw change sampled at edge 1 -> data_valid high after edge DEBOUNCE+3 (from IDLE, sw held steady).
REQ-027 SHALL ignore data_ready while in IDLE.

Reset
REQ-028 SHALL, on reset high at an edge, clear sync1, sync2, stable, stable_prev, counters, pending_mask, data_out, chg_mask, overrun, data_valid and enter IDLE, overriding all other activity including an in-flight transaction.
REQ-029 SHALL treat switches held high through reset as changes after release: first transaction appears DEBOUNCE+3 edges after the first non-reset edge.

Verification
REQ-030 SHALL cover (N_SW=4, DATA_WIDTH=8, DEBOUNCE=4, data_ready=1): sw 0000->0101 held -> data_valid high 7 edges later for one cycle, data_out=0x05, chg_mask=0101.
REQ-031 SHALL cover glitch: sw[0] high for 3 synchronised cycles then low -> no data_valid, data_out stays 0x00.
REQ-032 SHALL cover backpressure: data_ready=0, sw 0000->0001, later 0001->0011 -> first word 0x01/0001 held; on data_ready=1, next cycle 0x03/0010 with data_valid still high; overrun=0.
REQ-033 SHALL cover overrun: data_ready=0, three successive debounced changes 0001, 0011, 0111 -> overrun=1 sticky; after handshakes words 0x01 then 0x07 with chg_mask 0110.
REQ-034 SHALL cover reset mid-transaction: data_valid=1 holding 0x05, reset pulsed -> next cycle data_valid=0, data_out=0x00, overrun=0; sw still 0101 -> new 0x05 transaction 7 edges after release.
